// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencing controller for the EX stage: two-cycle internal multiply,
// external divider handshake, MTHI/MTLO writes, pipeline stall and HI/LO commit.
`timescale 1ns/1ps
module muldiv_ctrl #(
  parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        flush,
  input  logic [63:0] hilo_in,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic        div_start,
  output logic        div_sign,
  output logic        div_annul,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        stall_req,
  output logic        hilo_we,
  output logic [63:0] hilo_wdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, MUL, DIV_RUN, DONE} state_t;

  state_t              state, state_next;
  logic [31:0]         opa_q, opb_q;
  logic                sign_q;
  logic                start_q;
  logic [63:0]         result_q, result_next;
  logic                load_ops, load_result, accept;
  logic signed [32:0]  mul_a, mul_b;
  logic signed [65:0]  product;

  // Sign mode selects 33-bit sign- or zero-extension so one signed multiplier serves both.
  assign mul_a   = {sign_q & opa_q[31], opa_q};
  assign mul_b   = {sign_q & opb_q[31], opb_q};
  assign product = mul_a * mul_b;

  // Reset also masks acceptance so every output reads zero while rst is low.
  assign accept = op_valid & ~flush & rst;
  assign div_a  = opa_q;
  assign div_b  = opb_q;
  assign busy   = (state != IDLE);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next  = state;
    load_ops    = 1'b0;
    load_result = 1'b0;
    result_next = product[63:0];
    div_start   = 1'b0;
    div_sign    = 1'b0;
    div_annul   = 1'b0;
    stall_req   = 1'b0;
    hilo_we     = 1'b0;
    hilo_wdata  = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!op_code[2]) begin
            stall_req = 1'b1;
            load_ops  = 1'b1;
            if (!op_code[1]) begin
              state_next = MUL;
            end else if (opb != 32'd0) begin
              state_next = DIV_RUN;
            end else begin
              load_result = 1'b1;
              result_next = {opa, DIV0_LO};
              state_next  = DONE;
            end
          end else if (op_code == 3'd4) begin
            hilo_we    = 1'b1;
            hilo_wdata = {opa, hilo_in[31:0]};
          end else if (op_code == 3'd5) begin
            hilo_we    = 1'b1;
            hilo_wdata = {hilo_in[63:32], opa};
          end
        end
      end
      MUL: begin
        if (flush) begin
          state_next = IDLE;
        end else begin
          stall_req   = 1'b1;
          load_result = 1'b1;
          result_next = product[63:0];
          state_next  = DONE;
        end
      end
      DIV_RUN: begin
        div_start = start_q;
        div_sign  = sign_q;
        if (flush) begin
          div_annul  = 1'b1;
          state_next = IDLE;
        end else begin
          stall_req = 1'b1;
          if (div_ready) begin
            load_result = 1'b1;
            result_next = div_result;
            state_next  = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
        if (!flush) begin
          hilo_we    = 1'b1;
          hilo_wdata = result_q;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      sign_q   <= 1'b0;
      start_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state   <= state_next;
      start_q <= (state == IDLE) && (state_next == DIV_RUN);
      if (load_ops) begin
        opa_q  <= opa;
        opb_q  <= opb;
        sign_q <= ~op_code[0];
      end
      if (load_result) result_q <= result_next;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed cases plus random ops against an arithmetic
// model of MULT/MULTU/DIV/DIVU/MTHI/MTLO and a bench-held HI/LO register.
`timescale 1ns/1ps
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] opa, opb;
  logic        flush;
  logic [63:0] hilo_in;
  logic        div_ready;
  logic [63:0] div_result;
  logic        div_start, div_sign, div_annul;
  logic [31:0] div_a, div_b;
  logic        stall_req, hilo_we, busy;
  logic [63:0] hilo_wdata;

  logic [63:0] hilo;
  int          n_cmp = 0;
  int          n_err = 0;

  muldiv_ctrl dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code), .opa(opa), .opb(opb),
    .flush(flush), .hilo_in(hilo_in), .div_ready(div_ready), .div_result(div_result),
    .div_start(div_start), .div_sign(div_sign), .div_annul(div_annul), .div_a(div_a),
    .div_b(div_b), .stall_req(stall_req), .hilo_we(hilo_we), .hilo_wdata(hilo_wdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mul_model(input logic [2:0] op, input logic [31:0] a, b);
    longint          sp;
    longint unsigned up;
    if (op == 3'd0) begin
      sp = longint'($signed(a)) * longint'($signed(b));
      return sp;
    end
    up = {32'd0, a} * {32'd0, b};
    return up;
  endfunction

  function automatic logic [63:0] div_model(input logic [2:0] op, input logic [31:0] a, b);
    int q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (op == 3'd2) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {r, q};
    end
    return {a % b, a / b};
  endfunction

  task automatic drive_op(input logic [2:0] op, input logic [31:0] a, b);
    @(negedge clk);
    op_valid = 1'b1; op_code = op; opa = a; opb = b; flush = 1'b0; div_ready = 1'b0;
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    op_valid = 1'b0; flush = 1'b0; div_ready = 1'b0;
    #1;
  endtask

  task automatic do_mul(input logic [2:0] op, input logic [31:0] a, b);
    logic [63:0] exp;
    exp = mul_model(op, a, b);
    drive_op(op, a, b);
    check("mul_t0_stall", stall_req, 1'b1);
    check("mul_t0_we", hilo_we, 1'b0);
    @(negedge clk); #1;
    check("mul_t1_stall", stall_req, 1'b1);
    check("mul_t1_busy", busy, 1'b1);
    @(negedge clk); #1;
    check("mul_t2_we", hilo_we, 1'b1);
    check("mul_t2_stall", stall_req, 1'b0);
    check("mul_t2_wdata", hilo_wdata, exp);
    hilo = exp; hilo_in = hilo;
  endtask

  task automatic do_div(input logic [2:0] op, input logic [31:0] a, b, input int lat);
    logic [63:0] exp;
    exp = div_model(op, a, b);
    drive_op(op, a, b);
    check("div_t0_stall", stall_req, 1'b1);
    check("div_t0_start", div_start, 1'b0);
    if (b == 32'd0) begin
      @(negedge clk); #1;
      check("div0_start", div_start, 1'b0);
      check("div0_we", hilo_we, 1'b1);
      check("div0_wdata", hilo_wdata, exp);
      check("div0_stall", stall_req, 1'b0);
    end else begin
      for (int k = 0; k <= lat; k++) begin
        @(negedge clk);
        div_ready  = (k == lat);
        div_result = (k == lat) ? exp : 64'd0;
        #1;
        check("div_run_start", div_start, (k == 0));
        check("div_run_stall", stall_req, 1'b1);
        check("div_run_we", hilo_we, 1'b0);
        if (k == 0) begin
          check("div_sign", div_sign, (op == 3'd2));
          check("div_a", div_a, a);
          check("div_b", div_b, b);
        end
      end
      @(negedge clk);
      div_ready = 1'b0;
      #1;
      check("div_done_we", hilo_we, 1'b1);
      check("div_done_wdata", hilo_wdata, exp);
      check("div_done_stall", stall_req, 1'b0);
    end
    hilo = exp; hilo_in = hilo;
  endtask

  task automatic do_move(input logic hi, input logic [31:0] a);
    logic [63:0] exp;
    exp = hi ? {a, hilo[31:0]} : {hilo[63:32], a};
    drive_op(hi ? 3'd4 : 3'd5, a, $urandom);
    check("mv_we", hilo_we, 1'b1);
    check("mv_wdata", hilo_wdata, exp);
    check("mv_stall", stall_req, 1'b0);
    check("mv_busy", busy, 1'b0);
    hilo = exp; hilo_in = hilo;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, stall_req, 1'b0);
    check({tag, "_we"}, hilo_we, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_start"}, div_start, 1'b0);
    check({tag, "_annul"}, div_annul, 1'b0);
    check({tag, "_wdata"}, hilo_wdata, 64'd0);
    check({tag, "_div_a"}, div_a, 32'd0);
    check({tag, "_div_b"}, div_b, 32'd0);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;

    rst = 1'b0; op_valid = 1'b0; op_code = 3'd0; opa = '0; opb = '0; flush = 1'b0;
    div_ready = 1'b0; div_result = '0; hilo = '0; hilo_in = '0;
    #1;
    check_all_zero("reset");
    @(negedge clk); rst = 1'b1;

    do_mul(3'd0, 32'hFFFF_FFFE, 32'd3);
    do_mul(3'd1, 32'hFFFF_FFFE, 32'd3);
    do_div(3'd3, 32'd100, 32'd7, 33);
    do_div(3'd2, 32'hFFFF_FFF9, 32'd2, 4);
    do_div(3'd2, 32'd5, 32'd0, 0);
    do_div(3'd3, 32'd77, 32'd5, 0);

    // Flush during a divide at cycle 10, then a late ready, then MULTU 2x3.
    drive_op(3'd2, 32'd1000, 32'd3);
    for (int k = 1; k < 10; k++) begin
      @(negedge clk); #1;
      check("fl_run_stall", stall_req, 1'b1);
    end
    @(negedge clk); flush = 1'b1; #1;
    check("fl_annul", div_annul, 1'b1);
    check("fl_stall", stall_req, 1'b0);
    check("fl_we", hilo_we, 1'b0);
    idle_cycle();
    check("fl_idle", busy, 1'b0);
    @(negedge clk); div_ready = 1'b1; div_result = 64'h1234_5678_9ABC_DEF0; #1;
    check("late_rdy_we", hilo_we, 1'b0);
    idle_cycle();
    check("late_rdy_busy", busy, 1'b0);
    check("late_rdy_we2", hilo_we, 1'b0);
    do_mul(3'd1, 32'd2, 32'd3);

    // Ready and flush together: flush wins.
    drive_op(3'd3, 32'd50, 32'd6);
    @(negedge clk); #1;
    @(negedge clk); flush = 1'b1; div_ready = 1'b1; div_result = 64'hAAAA_BBBB_CCCC_DDDD; #1;
    check("fr_annul", div_annul, 1'b1);
    check("fr_we", hilo_we, 1'b0);
    idle_cycle();
    check("fr_busy", busy, 1'b0);
    check("fr_we2", hilo_we, 1'b0);

    // Flush in DONE suppresses the write.
    drive_op(3'd0, 32'd9, 32'd9);
    @(negedge clk); #1;
    @(negedge clk); flush = 1'b1; #1;
    check("fd_we", hilo_we, 1'b0);
    idle_cycle();
    check("fd_busy", busy, 1'b0);

    hilo = 64'h0000_0001_0000_0002; hilo_in = hilo;
    do_move(1'b1, 32'hDEAD_BEEF);
    check("mthi_model", hilo, 64'hDEAD_BEEF_0000_0002);

    // Flushed MTLO and ignored op code 6.
    drive_op(3'd5, 32'h1111_1111, 32'd0);
    flush = 1'b1; #1;
    check("mtlo_flush_we", hilo_we, 1'b0);
    drive_op(3'd6, 32'd1, 32'd1);
    check("op6_stall", stall_req, 1'b0);
    check("op6_we", hilo_we, 1'b0);
    idle_cycle();
    check("op6_busy", busy, 1'b0);

    // Random operations against the model.
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 5));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
      if (op == 3'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      case (op)
        3'd0, 3'd1: do_mul(op, a, b);
        3'd2, 3'd3: do_div(op, a, b, $urandom_range(0, 6));
        default:    do_move(op == 3'd4, a);
      endcase
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end

    // Asynchronous reset in the middle of a multiply.
    drive_op(3'd0, 32'd123, 32'd456);
    @(negedge clk); rst = 1'b0; #1;
    check_all_zero("rst_mul");
    @(negedge clk); op_valid = 1'b0; rst = 1'b1; #1;
    check("rst_rel_we", hilo_we, 1'b0);
    idle_cycle();
    check("rst_rel_we2", hilo_we, 1'b0);
    check("rst_rel_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencing controller for the EX-stage multiply/divide resource and the HI/LO write port. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and runs a registered two-cycle multiply internally. It drives the external iterative divider through its start/annul/ready handshake, and holds the pipeline with `stall_req` until the 64-bit result is committed to HI/LO. EX flush (exception) aborts any in-flight operation without writing HI/LO.

## Interface
- `DIV0_LO`, 32'hFFFF_FFFF: LO value written on divide-by-zero (HI gets dividend).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `op_valid` in 1: EX holds a mul/div/move-to-HI/LO op.
- `op_code` in 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6/7 ignored.
- `opa`, `opb` in 32: rs and rt values.
- `flush` in 1: kill the EX instruction this cycle.
- `hilo_in` in 64: current {HI, LO}.
- `div_ready` in 1: divider result valid; single-cycle pulse.
- `div_result` in 64: {remainder, quotient}.
- `div_start` out 1: one-cycle start pulse to divider.
- `div_sign` out 1: 1 = signed divide.
- `div_annul` out 1: abort divider.
- `div_a`, `div_b` out 32: latched dividend and divisor.
- `stall_req` out 1: hold IF–EX.
- `hilo_we` out 1: HI/LO write enable.
- `hilo_wdata` out 64: {HI, LO} write data.
- `busy` out 1: FSM not IDLE.

## Operation
- States:
  - IDLE
  - MUL: product stage.
  - DIV_RUN
  - DONE
- IDLE, `op_valid` & !`flush`:
  - op 0/1: latch `opa`/`opb` and sign mode, go to MUL.
  - op 2/3 with `opb`≠0: latch operands, go to DIV_RUN.
  - op 2/3 with `opb`=0: load result reg {`opa`, `DIV0_LO`}, go to DONE. The divider is never started.
  - op 4 (MTHI): `hilo_we`=1 combinationally, `hilo_wdata`={`opa`, `hilo_in[31:0]`}, stay in IDLE.
  - op 5 (MTLO): `hilo_we`=1 combinationally, `hilo_wdata`={`hilo_in[63:32]`, `opa`}, stay in IDLE.
- MUL:
  - MULT operands are sign-extended to 33 bits; MULTU operands are zero-extended.
  - Result reg ← low 64 bits of the product. Go to DONE.
- DIV_RUN:
  - `div_start`=1 only on the first cycle in the state.
  - `div_sign`=1 for DIV, 0 for DIVU, held for the whole state.
  - On `div_ready`=1: result reg ← `div_result`, go to DONE. A `div_ready` outside DIV_RUN is ignored.
- DONE: `hilo_we`=1, `hilo_wdata`=result reg, then go to IDLE.
  - DONE never re-accepts. EX advances at the end of DONE, so the next op is seen in IDLE.
- `stall_req` = (IDLE & `op_valid` & op∈{0..3} & !`flush`) | MUL | DIV_RUN.
  - Low in DONE. Low in any cycle with `flush`=1.
- `flush`=1 in MUL, DIV_RUN or DONE:
  - Next state IDLE.
  - `hilo_we` forced 0.
  - In DIV_RUN, `div_annul`=1 for that cycle.
- `flush` in IDLE suppresses acceptance and MTHI/MTLO writes.
- `busy` = state≠IDLE.
- `div_a`/`div_b` hold the latched operands until the next acceptance.

## Timing
- Reset (`rst`=0, asynchronous, valid mid-operation):
  - State IDLE.
  - Operand and result regs = 0.
  - `div_start`, `div_annul`, `stall_req`, `hilo_we`, `busy` = 0.
  - `hilo_wdata`, `div_a`, `div_b` = 0.
  - `div_annul` is not raised by reset.
- MULT/MULTU:
  - Accept at T0 (`stall_req`=1), MUL at T1 (`stall_req`=1), DONE at T2 (`hilo_we`=1, `stall_req`=0).
  - Total 3 cycles in EX.
- DIV/DIVU:
  - Accept at T0, `div_start` at T1.
  - Divider ready at Tn (n≥1 after T1).
  - DONE at Tn+1.
- Divide-by-zero: accept at T0, DONE at T1.
- MTHI/MTLO: 0 extra cycles; write in the EX cycle.
- `div_ready` coinciding with the `div_start` cycle is accepted.
- `div_ready` and `flush` in the same cycle: flush wins; no write, annul asserted.

## Test plan
- MULT `opa`=0xFFFFFFFE, `opb`=3:
  - `stall_req` high T0–T1.
  - T2: `hilo_we`=1, `hilo_wdata`=0xFFFFFFFF_FFFFFFFA.
- MULTU, same operands: T2 `hilo_wdata`=0x00000002_FFFFFFFA.
- DIVU 100/7, divider model ready 33 cycles after start:
  - Exactly one `div_start` pulse at T1, `div_sign`=0.
  - Stall through the ready cycle.
  - DONE `hilo_wdata`=0x00000002_0000000E.
  - DIV −7/2 (`opa`=0xFFFFFFF9, `opb`=2): `div_sign`=1, `hilo_wdata`=0xFFFFFFFF_FFFFFFFD.
- DIV `opa`=5, `opb`=0:
  - No `div_start`.
  - T1: `hilo_we`=1, `hilo_wdata`=0x00000005_FFFFFFFF.
- DIV in progress, `flush` at cycle 10:
  - `div_annul`=1 in cycle 10, `stall_req`=0, no `hilo_we`, IDLE at cycle 11.
  - A following MULTU 2×3 writes 0x00000000_00000006.
  - A late `div_ready` is ignored.
- MTHI `opa`=0xDEADBEEF, `hilo_in`=0x00000001_00000002:
  - Same-cycle `hilo_we`=1, `hilo_wdata`=0xDEADBEEF_00000002, `stall_req`=0.
- Asserting `rst`=0 during MUL forces all outputs to 0 immediately, with no write after release.
